// File: rtl/lzc_norm_pipe.sv
// ---------------------------------------------------------------------------
// lzc_norm_pipe
//   Two-stage pipelined normalizer. Stage 1 captures the operand together with
//   its leading-zero count; stage 2 left-shifts the operand by that count so
//   the result's MSB is 1. An all-zero operand yields count WIDTH, data 0 and
//   the zero flag set. Valid/ready handshakes on both sides run at full
//   throughput and are safe under backpressure. At most two operands are in
//   flight, and results leave in strict FIFO order.
//
// Optional feature (compile-time macro LZC_NORM_CNT_EN):
//   When defined, adds port zero_total. This is a saturating 32-bit count of
//   accepted all-zero operands, and it is cleared only by reset_n.
//
// Ports
//   clk        in   1      clock; all state changes on the rising edge
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      upstream operand valid
//   in_ready   out  1      block can accept an operand this cycle
//   in_data    in   WIDTH  operand, MSB = bit WIDTH-1
//   out_valid  out  1      normalized result valid
//   out_ready  in   1      downstream accepts result
//   out_data   out  WIDTH  in_data << zcnt, zero-filled
//   out_zcnt   out  CW     leading-zero count, 0..WIDTH
//   out_zero   out  1      operand was all zeros
//   zero_total out  32     (LZC_NORM_CNT_EN only) accepted all-zero operands
// ---------------------------------------------------------------------------
module lzc_norm_pipe #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_zcnt,
  output logic             out_zero
`ifdef LZC_NORM_CNT_EN
  ,
  output logic [31:0]      zero_total
`endif
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [CW-1:0]    r_s1_cnt;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_data;
  logic [CW-1:0]    r_s2_cnt;
  logic             r_s2_zero;

  logic [CW-1:0]    w_in_cnt;
  logic             w_in_fire;
  logic             w_s2_adv;

  // Leading-zero count of the incoming operand. The scan runs from the LSB
  // upward, so the last hit is the most significant set bit. No hit at all
  // leaves the all-zero value WIDTH.
  always_comb begin
    w_in_cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_data[i]) begin
        w_in_cnt = CW'(WIDTH - 1 - i);
      end
    end
  end

  // Stage 2 can take stage 1's operand when it is empty or is emptying this
  // cycle. in_ready therefore depends combinationally on out_ready. There is
  // deliberately no path from in_valid to any output.
  assign w_s2_adv  = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready  = ~r_s1_valid | w_s2_adv;
  assign w_in_fire = in_valid & in_ready;

  // Stage 1: operand and count capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_cnt   <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= in_data;
        r_s1_cnt   <= w_in_cnt;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: normalize. A shift by WIDTH (all-zero operand) naturally gives 0.
  // The registers only load on an advance, so a stalled result stays put.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_cnt   <= '0;
      r_s2_zero  <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= 1'b1;
        r_s2_data  <= r_s1_data << r_s1_cnt;
        r_s2_cnt   <= r_s1_cnt;
        r_s2_zero  <= (r_s1_cnt == CW'(WIDTH));
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_zcnt  = r_s2_cnt;
  assign out_zero  = r_s2_zero;

`ifdef LZC_NORM_CNT_EN
  logic [31:0] r_zero_total;

  // Counts accepted all-zero operands and sticks at the maximum value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zero_total <= '0;
    end else if (w_in_fire && (in_data == '0) && (r_zero_total != 32'hFFFF_FFFF)) begin
      r_zero_total <= r_zero_total + 32'd1;
    end
  end

  assign zero_total = r_zero_total;
`endif

endmodule
